// File: rtl/match_pkg.sv
// Shared types and constants for the match sequencer: phase encoding, HID keycodes,
// round-result codes and the saturating score helper.
package match_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      COUNTDOWN  = 3'd1,
      PLAY       = 3'd2,
      EXPLODE    = 3'd3,
      HOLD       = 3'd4,
      MATCH_OVER = 3'd5
   } phase_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2,
      WIN_DRAW = 2'd3
   } winner_t;

   localparam logic [7:0] KEY_ENTER = 8'd88;
   localparam logic [7:0] KEY_Y     = 8'd28;
   localparam logic [7:0] KEY_M     = 8'd16;
   localparam logic [7:0] KEY_P     = 8'd19;

   localparam int         TIMER_W   = 16;
   localparam logic [2:0] SCORE_MAX = 3'd7;

   function automatic logic [2:0] score_inc(input logic [2:0] s);
      return (s == SCORE_MAX) ? s : s + 3'd1;
   endfunction

endpackage

// File: rtl/match_controller_if.sv
// Bundle between the match sequencer and the rest of the game: frame/key/hit inputs
// in, phase and rendering/motion control flags out.
interface match_controller_if;
   import match_pkg::*;

   logic       frame_tick;
   logic [7:0] keycode;
   logic       tank1gaya;
   logic       tank2gaya;

   phase_t     phase;
   logic       game_on;
   logic       freeze;
   logic       respawn;
   logic [1:0] countdown_val;
   logic       explosion1_on;
   logic       explosion2_on;
   winner_t    round_winner;
   logic [2:0] score_p1;
   logic [2:0] score_p2;
   logic       match_over_p1;
   logic       match_over_p2;

   // The sequencer is the master: it owns every status/control output.
   modport master (
      input  frame_tick, keycode, tank1gaya, tank2gaya,
      output phase, game_on, freeze, respawn, countdown_val,
             explosion1_on, explosion2_on, round_winner,
             score_p1, score_p2, match_over_p1, match_over_p2
   );

   modport slave (
      output frame_tick, keycode, tank1gaya, tank2gaya,
      input  phase, game_on, freeze, respawn, countdown_val,
             explosion1_on, explosion2_on, round_winner,
             score_p1, score_p2, match_over_p1, match_over_p2
   );

endinterface

// File: rtl/frame_timer.sv
// Frame-tick down-counter: load presets the interval, done fires on the tick that
// finishes it, and the counter then reloads itself for the next interval.
module frame_timer
   import match_pkg::*;
(
   input  logic               fsm_clock,
   input  logic               reset,
   input  logic               tick,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               done
);

   logic [TIMER_W-1:0] count;

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge fsm_clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick) begin
         count <= (count == '0) ? load_val : count - TIMER_W'(1);
      end
   end

   assign done = tick && (count == '0);

endmodule

// File: rtl/match_controller.sv
// Match sequencer: menu, 3-2-1 countdown, play, explosion animation, round-result hold
// and match-over screen, with per-player round scores.
module match_controller
   import match_pkg::*;
#(
   parameter int WIN_SCORE   = 3,
   parameter int CD_FRAMES   = 60,
   parameter int EXPL_FRAMES = 8,
   parameter int EXPL_STEPS  = 6,
   parameter int HOLD_FRAMES = 120
)(
   input  logic               fsm_clock,
   input  logic               reset,
   match_controller_if.master bus
);

   localparam logic [2:0] WIN3      = 3'(WIN_SCORE);
   localparam logic [3:0] LAST_STEP = 4'(EXPL_STEPS - 1);

   phase_t             phase;
   phase_t             tgt;
   logic               leave;
   logic [7:0]         key_prev;
   logic [1:0]         cd_digit;
   logic [3:0]         step;
   logic               paused;
   logic               h1;
   logic               h2;
   logic               respawn_q;
   logic [2:0]         score_p1;
   logic [2:0]         score_p2;
   winner_t            winner;
   logic [TIMER_W-1:0] load_val;
   logic               tmr_done;

   // Timer preset for a phase: interval length minus one (the counter runs down to 0).
   function automatic logic [TIMER_W-1:0] frames_for(input phase_t p);
      case (p)
         COUNTDOWN: return TIMER_W'(CD_FRAMES - 1);
         EXPLODE:   return TIMER_W'(EXPL_FRAMES - 1);
         HOLD:      return TIMER_W'(HOLD_FRAMES - 1);
         default:   return '0;
      endcase
   endfunction

   wire press_enter   = (bus.keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
   wire press_y       = (bus.keycode == KEY_Y)     && (key_prev != KEY_Y);
   wire press_m       = (bus.keycode == KEY_M)     && (key_prev != KEY_M);
   wire press_p       = (bus.keycode == KEY_P)     && (key_prev != KEY_P);
   wire hit_any       = bus.tank1gaya || bus.tank2gaya;
   wire score_reached = (score_p1 >= WIN3) || (score_p2 >= WIN3);

   // Loading on a phase change discards any tick in that same cycle.
   assign load_val = frames_for(leave ? tgt : phase);

   frame_timer u_timer (
      .fsm_clock (fsm_clock),
      .reset     (reset),
      .tick      (bus.frame_tick),
      .load      (leave),
      .load_val  (load_val),
      .done      (tmr_done)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      leave = 1'b0;
      tgt   = IDLE;
      if (press_m) begin
         leave = 1'b1;
      end else begin
         case (phase)
            IDLE:       if (press_enter) begin leave = 1'b1; tgt = COUNTDOWN; end
            COUNTDOWN:  if (tmr_done && cd_digit == 2'd1) begin leave = 1'b1; tgt = PLAY; end
            PLAY:       if (!paused && hit_any) begin leave = 1'b1; tgt = EXPLODE; end
            EXPLODE:    if (tmr_done && step == LAST_STEP) begin leave = 1'b1; tgt = HOLD; end
            HOLD:       if (tmr_done) begin
                           leave = 1'b1;
                           tgt   = score_reached ? MATCH_OVER : COUNTDOWN;
                        end
            MATCH_OVER: if (press_y) begin leave = 1'b1; tgt = COUNTDOWN; end
            default:    leave = 1'b1;
         endcase
      end
   end

   always_ff @(posedge fsm_clock) begin
      if (reset) begin
         phase     <= IDLE;
         key_prev  <= '0;
         cd_digit  <= '0;
         step      <= '0;
         paused    <= 1'b0;
         h1        <= 1'b0;
         h2        <= 1'b0;
         respawn_q <= 1'b0;
         score_p1  <= '0;
         score_p2  <= '0;
         winner    <= WIN_NONE;
      end else begin
         key_prev  <= bus.keycode;
         respawn_q <= 1'b0;
         if (leave) begin
            phase  <= tgt;
            paused <= 1'b0;
            case (tgt)
               IDLE: begin
                  score_p1 <= '0;
                  score_p2 <= '0;
                  winner   <= WIN_NONE;
               end
               COUNTDOWN: begin
                  cd_digit  <= 2'd3;
                  respawn_q <= 1'b1;
                  winner    <= WIN_NONE;
                  // Only a new match (from menu or match-over) wipes the scores.
                  if (phase != HOLD) begin
                     score_p1 <= '0;
                     score_p2 <= '0;
                  end
               end
               EXPLODE: begin
                  h1   <= bus.tank1gaya;
                  h2   <= bus.tank2gaya;
                  step <= '0;
               end
               HOLD: begin
                  if (h1 && !h2) begin
                     score_p2 <= score_inc(score_p2);
                     winner   <= WIN_P2;
                  end else if (h2 && !h1) begin
                     score_p1 <= score_inc(score_p1);
                     winner   <= WIN_P1;
                  end else if (h1 && h2) begin
                     winner   <= WIN_DRAW;
                  end else begin
                     winner   <= WIN_NONE;
                  end
               end
               default: ;
            endcase
         end else begin
            case (phase)
               COUNTDOWN: if (tmr_done) cd_digit <= cd_digit - 2'd1;
               PLAY:      if (press_p)  paused   <= !paused;
               EXPLODE:   if (tmr_done) step     <= step + 4'd1;
               default: ;
            endcase
         end
      end
   end

   assign bus.phase         = phase;
   assign bus.game_on       = (phase == COUNTDOWN) || (phase == PLAY) || (phase == EXPLODE);
   assign bus.freeze        = !((phase == PLAY) && !paused);
   assign bus.respawn       = respawn_q;
   assign bus.countdown_val = (phase == COUNTDOWN) ? cd_digit : 2'd0;
   assign bus.explosion1_on = (phase == EXPLODE) && !step[0];
   assign bus.explosion2_on = (phase == EXPLODE) &&  step[0];
   assign bus.round_winner  = winner;
   assign bus.score_p1      = score_p1;
   assign bus.score_p2      = score_p2;
   assign bus.match_over_p1 = (phase == MATCH_OVER) && (score_p1 >= WIN3);
   assign bus.match_over_p2 = (phase == MATCH_OVER) && (score_p2 >= WIN3);

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: a tick-counting behavioural model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_match_controller;
   import match_pkg::*;

   localparam int WIN   = 3;
   localparam int CD    = 2;
   localparam int EXPL  = 1;
   localparam int STEPS = 6;
   localparam int HOLDF = 3;

   logic fsm_clock = 1'b0;
   logic reset;

   match_controller_if bus ();

   match_controller #(
      .WIN_SCORE   (WIN),
      .CD_FRAMES   (CD),
      .EXPL_FRAMES (EXPL),
      .EXPL_STEPS  (STEPS),
      .HOLD_FRAMES (HOLDF)
   ) dut (
      .fsm_clock (fsm_clock),
      .reset     (reset),
      .bus       (bus)
   );

   always #5 fsm_clock = ~fsm_clock;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase plus frames elapsed in it; digits and steps follow by division.
   phase_t     m_phase = IDLE;
   phase_t     m_nxt;
   int         m_ticks = 0;
   int         m_n;
   int         m_s1 = 0;
   int         m_s2 = 0;
   int         m_win = 0;
   bit         m_paused = 0;
   bit         m_h1 = 0;
   bit         m_h2 = 0;
   bit         m_resp = 0;
   bit         m_valid = 0;
   bit         pm, pe, py, pp;
   logic [7:0] m_kprev = '0;

   always @(posedge fsm_clock) begin
      pm = (bus.keycode == 8'd16) && (m_kprev != 8'd16);
      pe = (bus.keycode == 8'd88) && (m_kprev != 8'd88);
      py = (bus.keycode == 8'd28) && (m_kprev != 8'd28);
      pp = (bus.keycode == 8'd19) && (m_kprev != 8'd19);
      m_kprev = bus.keycode;
      m_resp  = 0;
      if (reset) begin
         m_phase = IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
         m_paused = 0; m_h1 = 0; m_h2 = 0; m_kprev = '0; m_valid = 1;
      end else begin
         m_n   = m_ticks + (bus.frame_tick ? 1 : 0);
         m_nxt = m_phase;
         if (pm) begin
            m_nxt = IDLE; m_s1 = 0; m_s2 = 0; m_paused = 0;
         end else begin
            case (m_phase)
               IDLE: if (pe) begin m_nxt = COUNTDOWN; m_s1 = 0; m_s2 = 0; m_resp = 1; end
               COUNTDOWN: if (m_n == 3 * CD) m_nxt = PLAY;
               PLAY: begin
                  if (!m_paused && (bus.tank1gaya || bus.tank2gaya)) begin
                     m_h1 = bus.tank1gaya; m_h2 = bus.tank2gaya; m_nxt = EXPLODE;
                  end else if (pp) m_paused = !m_paused;
               end
               EXPLODE: if (m_n == STEPS * EXPL) begin
                  m_nxt = HOLD;
                  if (m_h1 && m_h2) m_win = 3;
                  else if (m_h1) begin m_win = 2; m_s2 = (m_s2 < 7) ? m_s2 + 1 : 7; end
                  else begin m_win = 1; m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7; end
               end
               HOLD: if (m_n == HOLDF) begin
                  if (m_s1 >= WIN || m_s2 >= WIN) m_nxt = MATCH_OVER;
                  else begin m_nxt = COUNTDOWN; m_resp = 1; end
               end
               MATCH_OVER: if (py) begin m_nxt = COUNTDOWN; m_s1 = 0; m_s2 = 0; m_resp = 1; end
               default: m_nxt = IDLE;
            endcase
         end
         if (m_phase == PLAY && m_nxt != PLAY) m_paused = 0;
         m_ticks = (m_nxt != m_phase || pm) ? 0 : m_n;
         m_phase = m_nxt;
      end
   end

   always @(negedge fsm_clock) begin
      if (m_valid) begin
         check("phase",    bus.phase, m_phase);
         check("game_on",  bus.game_on,
               (m_phase == COUNTDOWN || m_phase == PLAY || m_phase == EXPLODE) ? 1 : 0);
         check("freeze",   bus.freeze, (m_phase == PLAY && !m_paused) ? 0 : 1);
         check("respawn",  bus.respawn, m_resp);
         check("cd_val",   bus.countdown_val, (m_phase == COUNTDOWN) ? 3 - m_ticks / CD : 0);
         check("expl1",    bus.explosion1_on, (m_phase == EXPLODE && (m_ticks / EXPL) % 2 == 0) ? 1 : 0);
         check("expl2",    bus.explosion2_on, (m_phase == EXPLODE && (m_ticks / EXPL) % 2 == 1) ? 1 : 0);
         check("score_p1", bus.score_p1, m_s1);
         check("score_p2", bus.score_p2, m_s2);
         check("mo_p1",    bus.match_over_p1, (m_phase == MATCH_OVER && m_s1 >= WIN) ? 1 : 0);
         check("mo_p2",    bus.match_over_p2, (m_phase == MATCH_OVER && m_s2 >= WIN) ? 1 : 0);
         if (m_phase == HOLD) check("winner", bus.round_winner, m_win);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge fsm_clock);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge fsm_clock); bus.frame_tick = 1'b1;
         @(negedge fsm_clock); bus.frame_tick = 1'b0;
      end
   endtask

   task automatic press(input logic [7:0] code);
      @(negedge fsm_clock); bus.keycode = code;
      @(negedge fsm_clock); bus.keycode = 8'd0;
   endtask

   task automatic hit(input logic a, input logic b);
      @(negedge fsm_clock); bus.tank1gaya = a; bus.tank2gaya = b;
      @(negedge fsm_clock); bus.tank1gaya = 1'b0; bus.tank2gaya = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.frame_tick = 1'b0;
      bus.keycode    = 8'd0;
      bus.tank1gaya  = 1'b0;
      bus.tank2gaya  = 1'b0;
      cycles(3);
      reset = 1'b0;
      cycles(2);
      check("lit_rst_phase",  bus.phase, IDLE);
      check("lit_rst_freeze", bus.freeze, 1);
      check("lit_rst_gameon", bus.game_on, 0);
      check("lit_rst_winner", bus.round_winner, 0);

      // Enter -> countdown 3,3,2,2,1,1 -> play
      press(8'd88);
      check("lit_enter_resp",  bus.respawn, 1);
      check("lit_enter_cd",    bus.countdown_val, 3);
      cycles(1);
      check("lit_resp_pulse",  bus.respawn, 0);
      ticks(2);
      check("lit_cd_two",      bus.countdown_val, 2);
      ticks(4);
      check("lit_play",        bus.phase, PLAY);
      check("lit_play_freeze", bus.freeze, 0);

      // P1 hit -> P2 wins the round
      hit(1'b1, 1'b0);
      check("lit_explode",     bus.explosion1_on, 1);
      ticks(1);
      check("lit_expl_odd",    bus.explosion2_on, 1);
      ticks(5);
      check("lit_hold_winner", bus.round_winner, 2);
      check("lit_hold_p2",     bus.score_p2, 1);
      ticks(3);

      // simultaneous hits -> draw
      ticks(6);
      hit(1'b1, 1'b1);
      ticks(6);
      check("lit_draw_winner", bus.round_winner, 3);
      check("lit_draw_p2",     bus.score_p2, 1);
      ticks(3);
      check("lit_draw_next",   bus.phase, COUNTDOWN);

      // three P1 round wins -> match over
      for (int r = 0; r < 3; r++) begin
         ticks(6);
         hit(1'b0, 1'b1);
         ticks(6);
         ticks(3);
      end
      check("lit_mo_phase", bus.phase, MATCH_OVER);
      check("lit_mo_p1",    bus.match_over_p1, 1);
      check("lit_mo_score", bus.score_p1, 3);
      press(8'd28);
      check("lit_y_score",  bus.score_p1, 0);
      check("lit_y_resp",   bus.respawn, 1);
      check("lit_y_phase",  bus.phase, COUNTDOWN);

      // held P toggles pause once; hit while paused ignored
      ticks(6);
      @(negedge fsm_clock); bus.keycode = 8'd19;
      cycles(50);
      bus.keycode = 8'd0;
      cycles(1);
      check("lit_pause_freeze", bus.freeze, 1);
      hit(1'b1, 1'b0);
      check("lit_pause_hit",    bus.phase, PLAY);
      press(8'd19);
      check("lit_unpause",      bus.freeze, 0);

      // M during explosion step 3
      hit(1'b1, 1'b0);
      ticks(3);
      check("lit_step3",     bus.explosion2_on, 1);
      press(8'd16);
      check("lit_m_phase",   bus.phase, IDLE);
      check("lit_m_expl",    {bus.explosion1_on, bus.explosion2_on}, 0);
      check("lit_m_scores",  {bus.score_p1, bus.score_p2}, 0);

      // Enter coinciding with a frame tick: that tick is not counted
      @(negedge fsm_clock); bus.keycode = 8'd88; bus.frame_tick = 1'b1;
      @(negedge fsm_clock); bus.keycode = 8'd0;  bus.frame_tick = 1'b0;
      ticks(5);
      check("lit_tick_edge_cd", bus.countdown_val, 1);

      // reset mid-countdown
      @(negedge fsm_clock); reset = 1'b1;
      @(negedge fsm_clock);
      check("lit_mid_rst_phase", bus.phase, IDLE);
      check("lit_mid_rst_cd",    bus.countdown_val, 0);
      check("lit_mid_rst_game",  bus.game_on, 0);
      reset = 1'b0;
      cycles(3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
